// File: rtl/demodulate_pair_reader_if.sv
// Bus bundle between the pair reader, the two demodulate RAMs and the downstream integrator.
// Ports: RAM read address/strobe + read data (both RAMs); product stream with valid/ready/last.
// master = reader side (drives addresses and products), slave = RAM/integrator side.
interface demodulate_pair_reader_if #(
  parameter int P       = 32,
  parameter int NP      = 1024,
  parameter int NB_DATA = 16
);
  localparam int BW = $clog2(P);
  localparam int KW = $clog2(NP);
  localparam int PW = 2 * NB_DATA + 1;

  // RAM read side
  logic [BW-1:0]             o_rd_block;
  logic [KW-1:0]             o_rd_bin_a;
  logic [KW-1:0]             o_rd_bin_b;
  logic                      o_rd_en;
  logic signed [NB_DATA-1:0] i_a_re;
  logic signed [NB_DATA-1:0] i_a_im;
  logic signed [NB_DATA-1:0] i_b_re;
  logic signed [NB_DATA-1:0] i_b_im;

  // product stream
  logic signed [PW-1:0]      o_prod_re;
  logic signed [PW-1:0]      o_prod_im;
  logic                      o_valid;
  logic                      i_ready;
  logic                      o_last;

  modport master (
    output o_rd_block, o_rd_bin_a, o_rd_bin_b, o_rd_en,
    input  i_a_re, i_a_im, i_b_re, i_b_im,
    output o_prod_re, o_prod_im, o_valid, o_last,
    input  i_ready
  );

  modport slave (
    input  o_rd_block, o_rd_bin_a, o_rd_bin_b, o_rd_en,
    output i_a_re, i_a_im, i_b_re, i_b_im,
    input  o_prod_re, o_prod_im, o_valid, o_last,
    output i_ready
  );
endinterface

// File: rtl/demodulate_pair_reader.sv
// Small synchronous first-word-fall-through FIFO.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: none internally; the caller must never push when full.
// Ports: clock/reset, push/push_dat, pop/pop_dat, empty flag, occupancy count.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 pop_dat,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // storage carries no reset: contents are only observed once count says so
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Complex demodulate pair reader: reads X_p[k1] and conj(X_p[k2]) and streams their product.
// Latency: read strobe at t, RAM data at t+1, product enters the FIFO end of t+1, o_valid at t+2.
// Backpressure: reads are issued only while FIFO occupancy plus in-flight reads leave room.
// Ports: clock, i_reset (sync, active high), i_enable, i_storage_ready, o_frame_done, o_busy,
//        bus (master modport: RAM read address/data and product valid/ready stream).
module demodulate_pair_reader #(
  parameter int P          = 32,
  parameter int NP         = 1024,
  parameter int NB_DATA    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_storage_ready,
  output logic                        o_frame_done,
  output logic                        o_busy,
  demodulate_pair_reader_if.master    bus
);
  localparam int BW = $clog2(P);
  localparam int KW = $clog2(NP);
  localparam int PW = 2 * NB_DATA + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = 2 * PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          armed;
  logic          start;
  logic          issue;

  // next address to issue, p innermost, k1 outermost
  logic [BW-1:0] p_cnt;
  logic [KW-1:0] k2_cnt;
  logic [KW-1:0] k1_cnt;
  logic          p_max;
  logic          k2_max;
  logic          k1_max;
  logic          last_addr;

  // one-cycle RAM pipeline tracking
  logic          rd_last;
  logic          d_vld;
  logic          d_last;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [FW-1:0] fifo_dat;
  logic          pop;
  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          drained;

  assign p_max     = (p_cnt  == BW'(P - 1));
  assign k2_max    = (k2_cnt == KW'(NP - 1));
  assign k1_max    = (k1_cnt == KW'(NP - 1));
  assign last_addr = p_max && k2_max && k1_max;

  // Reads still in the RAM pipeline already own a FIFO slot.
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(d_vld) + (CW+1)'(bus.o_rd_en);
  assign credit_ok   = (credit_used < (CW+1)'(FIFO_DEPTH));

  // Looking at this cycle's pop lets o_frame_done follow the final transfer by one cycle.
  assign drained = !d_vld && !bus.o_rd_en &&
                   ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    start    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_enable && i_storage_ready && armed) begin
          state_nx = S_READ;
          start    = 1'b1;
        end
      end
      S_READ: begin
        if (i_enable && credit_ok) begin
          issue = 1'b1;
          if (last_addr) begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state          <= S_IDLE;
      armed          <= 1'b1;
      p_cnt          <= '0;
      k2_cnt         <= '0;
      k1_cnt         <= '0;
      bus.o_rd_en    <= 1'b0;
      bus.o_rd_block <= '0;
      bus.o_rd_bin_a <= '0;
      bus.o_rd_bin_b <= '0;
      rd_last        <= 1'b0;
      d_vld          <= 1'b0;
      d_last         <= 1'b0;
    end else begin
      state <= state_nx;

      // A flag that stays high after a frame must drop once before it can start another.
      if (start) begin
        armed <= 1'b0;
      end else if (!i_storage_ready) begin
        armed <= 1'b1;
      end

      bus.o_rd_en <= issue;
      if (issue) begin
        bus.o_rd_block <= p_cnt;
        bus.o_rd_bin_a <= k1_cnt;
        bus.o_rd_bin_b <= k2_cnt;
        rd_last        <= p_max;
        if (p_max) begin
          p_cnt <= '0;
          if (k2_max) begin
            k2_cnt <= '0;
            k1_cnt <= k1_max ? '0 : k1_cnt + KW'(1);
          end else begin
            k2_cnt <= k2_cnt + KW'(1);
          end
        end else begin
          p_cnt <= p_cnt + BW'(1);
        end
      end

      d_vld  <= bus.o_rd_en;
      d_last <= rd_last;
    end
  end

  // Full-precision complex multiply; operands widened to the result width first.
  logic signed [PW-1:0] a_re_x;
  logic signed [PW-1:0] a_im_x;
  logic signed [PW-1:0] b_re_x;
  logic signed [PW-1:0] b_im_x;
  logic signed [PW-1:0] prod_re;
  logic signed [PW-1:0] prod_im;

  assign a_re_x  = {{(PW-NB_DATA){bus.i_a_re[NB_DATA-1]}}, bus.i_a_re};
  assign a_im_x  = {{(PW-NB_DATA){bus.i_a_im[NB_DATA-1]}}, bus.i_a_im};
  assign b_re_x  = {{(PW-NB_DATA){bus.i_b_re[NB_DATA-1]}}, bus.i_b_re};
  assign b_im_x  = {{(PW-NB_DATA){bus.i_b_im[NB_DATA-1]}}, bus.i_b_im};
  assign prod_re = (a_re_x * b_re_x) - (a_im_x * b_im_x);
  assign prod_im = (a_re_x * b_im_x) + (a_im_x * b_re_x);

  assign pop = bus.o_valid && bus.i_ready;

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (i_reset),
    .push     (d_vld),
    .push_dat ({d_last, prod_re, prod_im}),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Outputs forced to zero while empty so stale FIFO contents never show.
  assign bus.o_valid   = !fifo_empty;
  assign bus.o_last    = fifo_empty ? 1'b0 : fifo_dat[FW-1];
  assign bus.o_prod_re = fifo_empty ? '0 : fifo_dat[2*PW-1:PW];
  assign bus.o_prod_im = fifo_empty ? '0 : fifo_dat[PW-1:0];

  assign o_frame_done = (state == S_DONE);
  assign o_busy       = (state != S_IDLE);
endmodule

// File: tb/tb_demodulate_pair_reader.sv
module tb_demodulate_pair_reader;
  localparam int P  = 4;
  localparam int NP = 4;
  localparam int NB = 16;
  localparam int FD = 4;

  logic clock = 1'b0;
  logic i_reset;
  logic i_enable;
  logic i_storage_ready;
  logic o_frame_done;
  logic o_busy;

  always #5 clock = ~clock;

  demodulate_pair_reader_if #(.P(P), .NP(NP), .NB_DATA(NB)) bus ();

  demodulate_pair_reader #(.P(P), .NP(NP), .NB_DATA(NB), .FIFO_DEPTH(FD)) dut (
    .clock           (clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_storage_ready (i_storage_ready),
    .o_frame_done    (o_frame_done),
    .o_busy          (o_busy),
    .bus             (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // RAM contents: plain RAM holds X_p[k], conjugate RAM holds conj(X_p[k]) (or arbitrary data)
  int a_re [P][NP];
  int a_im [P][NP];
  int b_re [P][NP];
  int b_im [P][NP];

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return $signed(r);
  endfunction

  task automatic fill_pattern();
    for (int p = 0; p < P; p++)
      for (int k = 0; k < NP; k++) begin
        a_re[p][k] = p + 1; a_im[p][k] = k;
        b_re[p][k] = p + 1; b_im[p][k] = -k;
      end
  endtask

  task automatic fill_random();
    for (int p = 0; p < P; p++)
      for (int k = 0; k < NP; k++) begin
        a_re[p][k] = rnd16(); a_im[p][k] = rnd16();
        b_re[p][k] = rnd16(); b_im[p][k] = rnd16();
      end
  endtask

  // synchronous RAM: data for a strobe appears one cycle later
  always @(posedge clock) begin
    if (bus.o_rd_en) begin
      bus.i_a_re <= 16'(a_re[bus.o_rd_block][bus.o_rd_bin_a]);
      bus.i_a_im <= 16'(a_im[bus.o_rd_block][bus.o_rd_bin_a]);
      bus.i_b_re <= 16'(b_re[bus.o_rd_block][bus.o_rd_bin_b]);
      bus.i_b_im <= 16'(b_im[bus.o_rd_block][bus.o_rd_bin_b]);
    end
  end

  // downstream ready: 0 = always, 1 = pattern 1,0,0, 2 = random
  int rdy_mode = 0;
  int rdy_ph   = 0;
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clock); #2;
      case (rdy_mode)
        0: bus.i_ready = 1'b1;
        1: begin bus.i_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
        default: bus.i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor
  int     cyc = 0;
  longint rx_re [$];
  longint rx_im [$];
  bit     rx_last [$];
  int     issued = 0, xfers = 0, max_out = 0;
  int     first_rd_cyc = -1, first_vld_cyc = -1, last_xfer_cyc = -1, done_cyc = -1, done_n = 0;
  int     first_blk = -1, first_ba = -1, first_bb = -1;
  bit     prev_stall = 0;
  longint prev_re, prev_im;
  bit     prev_last;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (i_reset) begin
      issued = 0; xfers = 0; prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", longint'(bus.o_valid), 1);
        check("hold_re", longint'($signed(bus.o_prod_re)), prev_re);
        check("hold_im", longint'($signed(bus.o_prod_im)), prev_im);
        check("hold_last", longint'(bus.o_last), longint'(prev_last));
      end
      if (bus.o_rd_en) begin
        if (first_rd_cyc < 0) begin
          first_rd_cyc = cyc;
          first_blk = int'(bus.o_rd_block);
          first_ba  = int'(bus.o_rd_bin_a);
          first_bb  = int'(bus.o_rd_bin_b);
        end
        issued++;
      end
      if (bus.o_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.o_valid && bus.i_ready) begin
        rx_re.push_back(longint'($signed(bus.o_prod_re)));
        rx_im.push_back(longint'($signed(bus.o_prod_im)));
        rx_last.push_back(bus.o_last);
        xfers++;
        last_xfer_cyc = cyc;
      end
      if (o_frame_done) begin done_n++; done_cyc = cyc; end
      if (issued - xfers > max_out) max_out = issued - xfers;
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_re    = longint'($signed(bus.o_prod_re));
      prev_im    = longint'($signed(bus.o_prod_im));
      prev_last  = bus.o_last;
    end
  end

  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic clear_mon();
    rx_re.delete(); rx_im.delete(); rx_last.delete();
    issued = 0; xfers = 0; max_out = 0; done_n = 0;
    first_rd_cyc = -1; first_vld_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_frame();
    clear_mon();
    i_storage_ready = 1'b0;
    step();
    i_storage_ready = 1'b1;
    i_enable = 1'b1;
  endtask

  // Runs one full frame and compares against the k1/k2/p ordered reference product list.
  task automatic run_frame(input string nm, input bit gap);
    longint e_re [$];
    longint e_im [$];
    bit     e_last [$];
    int     t;
    bit     gap_done;
    for (int k1 = 0; k1 < NP; k1++)
      for (int k2 = 0; k2 < NP; k2++)
        for (int p = 0; p < P; p++) begin
          e_re.push_back(longint'(a_re[p][k1]) * b_re[p][k2] - longint'(a_im[p][k1]) * b_im[p][k2]);
          e_im.push_back(longint'(a_re[p][k1]) * b_im[p][k2] + longint'(a_im[p][k1]) * b_re[p][k2]);
          e_last.push_back(p == P - 1);
        end
    start_frame();
    t = 0;
    gap_done = 0;
    while (done_n == 0 && t < 3000) begin
      step();
      t++;
      if (gap && !gap_done && rx_re.size() >= 20) begin
        gap_done = 1;
        i_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
          step();
          check({nm, "_gap_rd_en"}, longint'(bus.o_rd_en), 0);
        end
        i_enable = 1'b1;
      end
    end
    check({nm, "_done_seen"}, longint'(done_n > 0), 1);
    step(); step();
    check({nm, "_count"}, rx_re.size(), P * NP * NP);
    for (int i = 0; i < e_re.size(); i++) begin
      if (i < rx_re.size()) begin
        check($sformatf("%s_re[%0d]", nm, i), rx_re[i], e_re[i]);
        check($sformatf("%s_im[%0d]", nm, i), rx_im[i], e_im[i]);
        check($sformatf("%s_last[%0d]", nm, i), longint'(rx_last[i]), longint'(e_last[i]));
      end
    end
    check({nm, "_latency"}, first_vld_cyc - first_rd_cyc, 2);
    check({nm, "_first_blk"}, first_blk, 0);
    check({nm, "_first_k1"}, first_ba, 0);
    check({nm, "_first_k2"}, first_bb, 0);
    check({nm, "_done_timing"}, done_cyc, last_xfer_cyc + 1);
    check({nm, "_done_once"}, done_n, 1);
    check({nm, "_idle_after"}, longint'(o_busy), 0);
    check({nm, "_fifo_bound"}, longint'(max_out <= FD), 1);
  endtask

  typedef struct {
    int     a_re, a_im, b_re, b_im;
    longint e_re, e_im;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n_before;
    int t;

    tbl[0] = '{-32768, -32768, -32768,  32767,  64'sd2147450880,  64'sd32768};
    tbl[1] = '{     1,      2,      3,      4,  -64'sd5,           64'sd10};
    tbl[2] = '{ 32767,  32767,  32767,  32767,  64'sd0,            64'sd2147352578};
    tbl[3] = '{-32768,      0, -32768,      0,  64'sd1073741824,   64'sd0};
    tbl[4] = '{-32768, -32768,  32767,  32767,  64'sd0,           -64'sd2147418112};
    tbl[5] = '{     0,     -1,      0,      1,  64'sd1,            64'sd0};
    tbl[6] = '{-32768, -32768, -32768, -32768,  64'sd0,            64'sd2147483648};
    tbl[7] = '{   100,   -200,   -300,    400,  64'sd50000,        64'sd100000};

    i_reset = 1'b1;
    i_enable = 1'b0;
    i_storage_ready = 1'b0;
    fill_pattern();
    repeat (3) step();
    check("rst_valid", longint'(bus.o_valid), 0);
    check("rst_rd_en", longint'(bus.o_rd_en), 0);
    check("rst_busy", longint'(o_busy), 0);
    check("rst_done", longint'(o_frame_done), 0);
    check("rst_last", longint'(bus.o_last), 0);
    check("rst_prod_re", longint'(bus.o_prod_re), 0);
    check("rst_prod_im", longint'(bus.o_prod_im), 0);
    check("rst_rd_block", longint'(bus.o_rd_block), 0);
    check("rst_rd_bin_a", longint'(bus.o_rd_bin_a), 0);
    check("rst_rd_bin_b", longint'(bus.o_rd_bin_b), 0);
    i_reset = 1'b0;
    step();

    // storage ready without enable: nothing happens
    clear_mon();
    i_storage_ready = 1'b1;
    repeat (20) step();
    check("noenable_busy", longint'(o_busy), 0);
    check("noenable_reads", issued, 0);

    // pattern RAM, free-flowing output
    rdy_mode = 0;
    fill_pattern();
    run_frame("pattern", 0);

    // flag held high after a frame must not retrigger
    n_before = issued;
    repeat (20) step();
    check("no_retrigger_busy", longint'(o_busy), 0);
    check("no_retrigger_reads", issued, n_before);

    // stalled output, ready 1,0,0
    rdy_mode = 1;
    run_frame("stall", 0);

    // arithmetic table: vectors placed at (k1,k2)=(0,0), one per block
    rdy_mode = 2;
    for (int f = 0; f < 2; f++) begin
      fill_random();
      for (int p = 0; p < P; p++) begin
        a_re[p][0] = tbl[f*4+p].a_re; a_im[p][0] = tbl[f*4+p].a_im;
        b_re[p][0] = tbl[f*4+p].b_re; b_im[p][0] = tbl[f*4+p].b_im;
      end
      run_frame($sformatf("arith%0d", f), 0);
      for (int p = 0; p < P; p++) begin
        if (p < rx_re.size()) begin
          check($sformatf("tbl%0d_re", f*4+p), rx_re[p], tbl[f*4+p].e_re);
          check($sformatf("tbl%0d_im", f*4+p), rx_im[p], tbl[f*4+p].e_im);
        end
      end
    end

    // enable gap mid-frame
    rdy_mode = 0;
    fill_random();
    run_frame("gap", 1);

    // reset mid-frame at product 20
    rdy_mode = 0;
    start_frame();
    t = 0;
    while (rx_re.size() < 20 && t < 500) begin step(); t++; end
    check("rstmid_reached", longint'(rx_re.size() >= 20), 1);
    i_reset = 1'b1;
    step();
    check("rstmid_valid", longint'(bus.o_valid), 0);
    check("rstmid_busy", longint'(o_busy), 0);
    check("rstmid_rd_en", longint'(bus.o_rd_en), 0);
    i_reset = 1'b0;
    i_enable = 1'b0;
    i_storage_ready = 1'b0;
    step();
    check("rstmid_idle", longint'(o_busy), 0);
    run_frame("after_reset", 0);

    // randomized frames with random backpressure
    rdy_mode = 2;
    for (int r = 0; r < 2; r++) begin
      fill_random();
      run_frame($sformatf("rand%0d", r), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
